unidade_controle_jogo_timeout: RTL and testbench

Moore FSM that sequences the memory-game datapath: play counter (E), round counter (R), play register, and sequence RAM write.
- Each round, the player repeats the stored sequence, then enters one new play, which is written to RAM.
- Contains an internal play-timeout counter; the game ends on a wrong play, on timeout, or on a win after the final round.
- Sits beside the fluxo_dados in the top-level game module.

---
 rtl/jogo_pkg.sv | 27 ++
 rtl/contador_timeout.sv | 38 +++
 rtl/unidade_controle_jogo_timeout.sv | 162 ++++++++++++++++
 tb/tb_unidade_controle_jogo_timeout.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared state codes and game constants for the memory-game control unit.
package jogo_pkg;

  localparam int unsigned DEFAULT_TIMEOUT_CICLOS = 5000;
  localparam int unsigned N_RODADAS              = 16;

  typedef enum logic [3:0] {
    StInicial       = 4'h0,
    StPreparacao    = 4'h1,
    StIniciaRodada  = 4'h2,
    StEsperaJogada  = 4'h3,
    StRegistra      = 4'h4,
    StComparacao    = 4'h5,
    StProximaJogada = 4'h6,
    StPreparaNova   = 4'h7,
    StEsperaNova    = 4'h8,
    StRegistraNova  = 4'h9,
    StGrava         = 4'hA,
    StProximaRodada = 4'hB,
    StFimGanhou     = 4'hC,
    StFimTimeout    = 4'hD,
    StFimPerdeu     = 4'hE
  } estado_e;

  localparam logic [3:0] EstadoInvalido = 4'hF;

endpackage

// File: rtl/contador_timeout.sv
// Clearable, saturating up-counter with a terminal-count flag.
module contador_timeout #(
  parameter int unsigned Max   = 4999,
  parameter int unsigned Width = 13
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o,
  output logic             tc_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != MaxVal)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == MaxVal);

endmodule

// File: rtl/unidade_controle_jogo_timeout.sv
// Moore control unit for the memory game; play timeout present only with JOGO_TIMEOUT_EN defined.
module unidade_controle_jogo_timeout #(
  parameter int unsigned TIMEOUT_CICLOS = jogo_pkg::DEFAULT_TIMEOUT_CICLOS,
  parameter int unsigned TIMEOUT_W      = 13
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic                 jogada,
  input  logic                 jogada_correta,
  input  logic                 enderecoIgualRodada,
  input  logic                 fimR,
  output logic                 zeraE,
  output logic                 contaE,
  output logic                 zeraR,
  output logic                 contaR,
  output logic                 registraR,
  output logic                 gravaM,
  output logic                 ganhou,
  output logic                 perdeu,
  output logic                 pronto,
  output logic                 db_timeout,
  output logic [3:0]           db_estado,
  output logic [TIMEOUT_W-1:0] db_contagem_timeout
);

  import jogo_pkg::*;

  estado_e estado_q, estado_d;
  logic    zera_t, conta_t, timeout_int;

`ifdef JOGO_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] contagem;
  logic                 terminal;

  contador_timeout #(
    .Max   (TIMEOUT_CICLOS - 1),
    .Width (TIMEOUT_W)
  ) u_contador_timeout (
    .clk_i   (clock),
    .rst_ni  (reset),
    .clr_i   (zera_t),
    .en_i    (conta_t),
    .count_o (contagem),
    .tc_o    (terminal)
  );

  assign timeout_int         = conta_t & terminal;
  assign db_contagem_timeout = contagem;
`else
  logic unused_timeout;
  assign unused_timeout      = ^{zera_t, conta_t, TIMEOUT_CICLOS[0]};
  assign timeout_int         = 1'b0;
  assign db_contagem_timeout = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= StInicial;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    zeraE      = 1'b0;
    contaE     = 1'b0;
    zeraR      = 1'b0;
    contaR     = 1'b0;
    registraR  = 1'b0;
    gravaM     = 1'b0;
    ganhou     = 1'b0;
    perdeu     = 1'b0;
    pronto     = 1'b0;
    db_timeout = 1'b0;
    zera_t     = 1'b0;
    conta_t    = 1'b0;
    db_estado  = estado_q;

    case (estado_q)
      StInicial: begin
        if (iniciar) estado_d = StPreparacao;
      end
      StPreparacao: begin
        zeraE    = 1'b1;
        zeraR    = 1'b1;
        zera_t   = 1'b1;
        estado_d = StIniciaRodada;
      end
      StIniciaRodada: begin
        zeraE    = 1'b1;
        zera_t   = 1'b1;
        estado_d = StEsperaJogada;
      end
      StEsperaJogada: begin
        conta_t = 1'b1;
        // A press on the terminal cycle still counts as a play.
        if (jogada)           estado_d = StRegistra;
        else if (timeout_int) estado_d = StFimTimeout;
      end
      StRegistra: begin
        registraR = 1'b1;
        estado_d  = StComparacao;
      end
      StComparacao: begin
        if (!jogada_correta)           estado_d = StFimPerdeu;
        else if (!enderecoIgualRodada) estado_d = StProximaJogada;
        else if (fimR)                 estado_d = StFimGanhou;
        else                           estado_d = StPreparaNova;
      end
      StProximaJogada: begin
        contaE   = 1'b1;
        zera_t   = 1'b1;
        estado_d = StEsperaJogada;
      end
      StPreparaNova: begin
        contaE   = 1'b1;
        zera_t   = 1'b1;
        estado_d = StEsperaNova;
      end
      StEsperaNova: begin
        conta_t = 1'b1;
        if (jogada)           estado_d = StRegistraNova;
        else if (timeout_int) estado_d = StFimTimeout;
      end
      StRegistraNova: begin
        registraR = 1'b1;
        estado_d  = StGrava;
      end
      StGrava: begin
        gravaM   = 1'b1;
        estado_d = StProximaRodada;
      end
      StProximaRodada: begin
        contaR   = 1'b1;
        estado_d = StIniciaRodada;
      end
      StFimGanhou: begin
        ganhou = 1'b1;
        pronto = 1'b1;
        if (iniciar) estado_d = StPreparacao;
      end
      StFimTimeout: begin
        perdeu     = 1'b1;
        db_timeout = 1'b1;
        pronto     = 1'b1;
        if (iniciar) estado_d = StPreparacao;
      end
      StFimPerdeu: begin
        perdeu = 1'b1;
        pronto = 1'b1;
        if (iniciar) estado_d = StPreparacao;
      end
      default: begin
        estado_d  = StInicial;
        db_estado = EstadoInvalido;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle_jogo_timeout.sv
// Scoreboard bench: a player model drives random games, a monitor checks RAM writes and game ends.
module tb_unidade_controle_jogo_timeout;

  localparam int unsigned TW = 13;
`ifdef JOGO_TIMEOUT_EN
  localparam int unsigned ExpLateCount = 4999;
`else
  localparam int unsigned ExpLateCount = 0;
`endif

  logic clock = 1'b0, reset = 1'b0, iniciar = 1'b0, jogada = 1'b0;
  logic jogada_correta, enderecoIgualRodada, fimR;
  logic zeraE, contaE, zeraR, contaR, registraR, gravaM;
  logic ganhou, perdeu, pronto, db_timeout;
  logic [3:0]    db_estado;
  logic [TW-1:0] db_contagem_timeout;
  logic [9:0]    outs;

  unidade_controle_jogo_timeout #(
    .TIMEOUT_CICLOS (5000),
    .TIMEOUT_W      (TW)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .iniciar             (iniciar),
    .jogada              (jogada),
    .jogada_correta      (jogada_correta),
    .enderecoIgualRodada (enderecoIgualRodada),
    .fimR                (fimR),
    .zeraE               (zeraE),
    .contaE              (contaE),
    .zeraR               (zeraR),
    .contaR              (contaR),
    .registraR           (registraR),
    .gravaM              (gravaM),
    .ganhou              (ganhou),
    .perdeu              (perdeu),
    .pronto              (pronto),
    .db_timeout          (db_timeout),
    .db_estado           (db_estado),
    .db_contagem_timeout (db_contagem_timeout)
  );

  always #5 clock = ~clock;

  assign outs = {zeraE, contaE, zeraR, contaR, registraR, gravaM, ganhou, perdeu, pronto, db_timeout};

  // Datapath environment: E/R counters, play register, sequence RAM (address 0 preloaded).
  logic [3:0] e_q, r_q, play_q, botao = 4'h0, ram0 = 4'h0;
  logic [3:0] ram [16];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      e_q <= 4'h0; r_q <= 4'h0; play_q <= 4'h0;
    end else begin
      if (zeraE) e_q <= 4'h0; else if (contaE) e_q <= e_q + 4'h1;
      if (zeraR) r_q <= 4'h0; else if (contaR) r_q <= r_q + 4'h1;
      if (registraR) play_q <= botao;
    end
  end

  always @(posedge clock) if (gravaM) ram[e_q] <= play_q;

  assign jogada_correta      = (play_q == ((e_q == 4'h0) ? ram0 : ram[e_q]));
  assign enderecoIgualRodada = (e_q == r_q);
  assign fimR                = (r_q == 4'hF);

  typedef struct {
    bit          is_end;
    int unsigned addr;
    int unsigned data;
    int unsigned code;
    bit          g, p, t;
  } exp_t;

  exp_t sb[$];
  exp_t x;
  int   errors = 0, checks = 0;
  int   grava_cnt = 0, contar_cnt = 0;
  logic pronto_prev = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk_wr(input int unsigned addr, input int unsigned data);
    exp_t e;
    e = '{is_end: 1'b0, addr: addr, data: data, code: 0, g: 1'b0, p: 1'b0, t: 1'b0};
    return e;
  endfunction

  function automatic exp_t mk_end(input int unsigned code, input bit g, input bit p, input bit t);
    exp_t e;
    e = '{is_end: 1'b1, addr: 0, data: 0, code: code, g: g, p: p, t: t};
    return e;
  endfunction

  // Monitor: every RAM write and every game end must match the oldest expectation.
  always @(negedge clock) begin
    if (gravaM || (pronto && !pronto_prev)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_output", 32'(db_estado), 99);
      end else begin
        x = sb.pop_front();
        chk("sb_kind", {31'd0, !gravaM}, {31'd0, x.is_end});
        if (!x.is_end) begin
          chk("wr_addr", 32'(e_q), x.addr);
          chk("wr_data", 32'(play_q), x.data);
        end else begin
          chk("end_state", 32'(db_estado), x.code);
          chk("end_ganhou", 32'(ganhou), 32'(x.g));
          chk("end_perdeu", 32'(perdeu), 32'(x.p));
          chk("end_timeout", 32'(db_timeout), 32'(x.t));
        end
      end
    end
    if (gravaM) grava_cnt++;
    if (contaR) contar_cnt++;
    pronto_prev = pronto;
  end

  task automatic wait_state(input int unsigned code, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (db_estado == 4'h3 || db_estado == 4'h8 || db_estado >= 4'hC) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_state", ok ? 32'(db_estado) : 32'd16, code);
    ok = ok && (32'(db_estado) == code);
  endtask

  task automatic press(input logic [3:0] v, input int unsigned dly);
    repeat (dly) @(negedge clock);
    botao  = v;
    jogada = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
  endtask

  task automatic wait_end();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (pronto) begin
        seen = 1'b1;
        break;
      end
    end
    chk("end_reached", 32'(seen), 1);
  endtask

  task automatic start_game(input bit hold);
    @(negedge clock);
    iniciar = 1'b1;
    @(negedge clock);
    if (!hold) iniciar = 1'b0;
    chk("prep_state", 32'(db_estado), 1);
    chk("prep_outs", 32'({zeraE, zeraR, contaE, contaR}), 32'hC);
    @(negedge clock);
    chk("inicia_state", 32'(db_estado), 2);
    chk("inicia_outs", 32'({zeraE, zeraR}), 32'h2);
    chk("inicia_count", 32'(db_contagem_timeout), 0);
    grava_cnt  = 0;
    contar_cnt = 0;
  endtask

  task automatic async_reset_check();
    #1 reset = 1'b0;
    #1;
    chk("rst_async_state", 32'(db_estado), 0);
    chk("rst_async_outs", 32'(outs), 0);
    chk("rst_async_count", 32'(db_contagem_timeout), 0);
    sb.delete();
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Press exactly on the cycle where the counter sits at its terminal value.
  task automatic late_press(input logic [3:0] v);
    repeat (4999) @(negedge clock);
    chk("late_still_wait", 32'(db_estado), 3);
    chk("late_count", 32'(db_contagem_timeout), ExpLateCount);
    botao  = v;
    jogada = 1'b1;
    @(negedge clock);
    jogada = 1'b0;
    chk("late_to_registra", 32'(db_estado), 4);
  endtask

  task automatic timeout_check();
`ifdef JOGO_TIMEOUT_EN
    int k;
    sb.push_back(mk_end(13, 1'b0, 1'b1, 1'b1));
    for (k = 1; k <= 5100; k++) begin
      @(negedge clock);
      if (k == 4999) chk("to_count_4999", 32'(db_contagem_timeout), 4999);
      if (db_estado == 4'hD) break;
    end
    chk("timeout_latency", k, 5000);
    chk("timeout_flag", 32'(db_timeout), 1);
`else
    repeat (5100) @(negedge clock);
    chk("no_timeout_state", 32'(db_estado), 8);
    chk("no_timeout_flag", 32'(db_timeout), 0);
    chk("no_timeout_count", 32'(db_contagem_timeout), 0);
`endif
  endtask

  // Player model: round r repeats plays 0..r, then adds one new play written at address r+1.
  task automatic run_game(input int wrong_r, input int wrong_i, input int late_r,
                          input int to_r, input int rst_r);
    bit         ok;
    logic [3:0] seq[$];
    logic [3:0] v;
    seq.delete();
    seq.push_back(ram0);
    for (int r = 0; r < 16; r++) begin
      if (r == 15) iniciar = 1'b0;
      for (int i = 0; i <= r; i++) begin
        wait_state(3, ok);
        if (!ok) return;
        if (r == rst_r) begin
          async_reset_check();
          return;
        end
        v = seq[i];
        if (r == wrong_r && i == wrong_i) begin
          v = v ^ 4'h1;
          sb.push_back(mk_end(14, 1'b0, 1'b1, 1'b0));
          press(v, $urandom_range(0, 3));
          wait_end();
          return;
        end
        if (r == late_r && i == 0) late_press(v);
        else press(v, $urandom_range(0, 3));
      end
      if (r == 15) begin
        sb.push_back(mk_end(12, 1'b1, 1'b0, 1'b0));
        wait_end();
        return;
      end
      wait_state(8, ok);
      if (!ok) return;
      if (r == to_r) begin
        timeout_check();
        return;
      end
      v = 4'($urandom);
      sb.push_back(mk_wr(r + 1, 32'(v)));
      press(v, $urandom_range(0, 3));
      seq.push_back(v);
    end
  endtask

  initial begin
    ram0 = 4'($urandom);
    repeat (2) @(negedge clock);
    chk("reset_state", 32'(db_estado), 0);
    chk("reset_outs", 32'(outs), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_state", 32'(db_estado), 0);

    // Full win, iniciar held high during play (must be ignored).
    start_game(1'b1);
    run_game(-1, -1, -1, -1, -1);
    chk("win_state", 32'(db_estado), 12);
    chk("win_grava_cnt", grava_cnt, 15);
    chk("win_contaR_cnt", contar_cnt, 15);

    // Wrong play at round 2 play 1, with a terminal-cycle press in round 1.
    start_game(1'b0);
    run_game(2, 1, 1, -1, -1);
    chk("lose_state", 32'(db_estado), 14);
    chk("lose_grava_cnt", grava_cnt, 2);
    chk("lose_contaR_cnt", contar_cnt, 2);

    // Stall in espera_nova of round 2.
    start_game(1'b0);
    run_game(-1, -1, -1, 2, -1);

    @(negedge clock);
    async_reset_check();

    // Reset mid espera_jogada of round 2.
    start_game(1'b0);
    run_game(-1, -1, -1, -1, 2);
    repeat (3) @(negedge clock);
    chk("post_reset_idle", 32'(db_estado), 0);
    chk("post_reset_grava_cnt", grava_cnt, 2);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
